// File: rtl/mem_pipelined.sv
// mem_pipelined: single-port word memory with a fixed-latency read pipeline.
// Writes commit at the issuing edge. Read data returns LATENCY cycles after
// issue, accompanied by a one-cycle data_valid strobe.
// Optional feature macro: MEM_BYTE_WE_EN adds a per-byte write enable port 'be'.
//
// Request/response protocol:
//   enable=1 in a cycle issues one request at the next rising edge. There is
//   no ready; the memory accepts every request. A read's response shows up as
//   data_valid=1 for exactly one cycle. There is no backpressure, so the
//   consumer must take data_out in any cycle where data_valid=1. Responses
//   return in issue order.
module mem_pipelined #(
  parameter int DWIDTH  = 16,
  parameter int AWIDTH  = 16,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] data_in,
`ifdef MEM_BYTE_WE_EN
  input  logic [DWIDTH/8-1:0] be,
`endif
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("mem_pipelined: LATENCY must be in 1..8");
  end

`ifdef MEM_BYTE_WE_EN
  if (DWIDTH % 8 != 0) begin : g_bad_dwidth
    $error("mem_pipelined: DWIDTH must be a multiple of 8 with byte enables");
  end
`endif

  // Storage array; deliberately not reset so the image survives rst_n.
  logic [DWIDTH-1:0] mem [2**AWIDTH];

  // Pipeline registers. The last stage is the output register itself.
  logic [LATENCY-1:0] stage_valid;
  logic [DWIDTH-1:0]  stage_data [LATENCY];

  logic rd_issue;
  assign rd_issue = enable && !wr;

  // Array write port: commit the write at the issuing edge.
  always_ff @(posedge clk) begin
    if (enable && wr) begin
`ifdef MEM_BYTE_WE_EN
      for (int i = 0; i < DWIDTH/8; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= data_in[i*8 +: 8];
      end
`else
      mem[addr] <= data_in;
`endif
    end
  end

  // Read pipeline: sample the array at issue, then shift one stage per cycle.
  // Data registers only load behind a valid bit, so the last stage holds the
  // previously returned word while no read is completing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int k = 0; k < LATENCY; k++) stage_data[k] <= '0;
    end else begin
      stage_valid[0] <= rd_issue;
      if (rd_issue) stage_data[0] <= mem[addr];
      for (int k = 1; k < LATENCY; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        if (stage_valid[k-1]) stage_data[k] <= stage_data[k-1];
      end
    end
  end

  assign data_out   = stage_data[LATENCY-1];
  assign data_valid = stage_valid[LATENCY-1];
  assign busy       = |stage_valid;

endmodule

// File: tb/tb_mem_pipelined.sv
// tb_mem_pipelined: randomized and directed stimulus for mem_pipelined with a
// reference memory and an in-order expected-response scoreboard.
module tb_mem_pipelined;

  localparam int W = 16;
  localparam int A = 16;
  localparam int L = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         enable = 1'b0;
  logic         wr = 1'b0;
  logic [A-1:0] addr = '0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
`ifdef MEM_BYTE_WE_EN
  logic [W/8-1:0] be = '1;
`endif

  mem_pipelined #(.DWIDTH(W), .AWIDTH(A), .LATENCY(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .wr(wr),
    .addr(addr),
    .data_in(data_in),
`ifdef MEM_BYTE_WE_EN
    .be(be),
`endif
    .data_out(data_out),
    .data_valid(data_valid),
    .busy(busy)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] model [int];
  logic [W-1:0] exp_q [$];
  int           due_q [$];
  logic [W-1:0] last_out = '0;
  int           neg_cnt = 0;
  int           checks = 0;
  int           errors = 0;

  // ---------------- driver tasks ----------------
  // One operation per cycle; inputs change 1ns after the falling edge.
  // A read issued here is sampled at falling edge neg_cnt + L.
  task automatic op(input logic e, input logic w, input logic [A-1:0] a,
                    input logic [W-1:0] d);
    @(negedge clk);
    #1;
    enable = e; wr = w; addr = a; data_in = d;
    if (e && w) begin
`ifdef MEM_BYTE_WE_EN
      logic [W-1:0] cur;
      cur = model.exists(int'(a)) ? model[int'(a)] : '0;
      for (int i = 0; i < W/8; i++) if (be[i]) cur[i*8 +: 8] = d[i*8 +: 8];
      model[int'(a)] = cur;
`else
      model[int'(a)] = d;
`endif
    end else if (e) begin
      exp_q.push_back(model[int'(a)]);
      due_q.push_back(neg_cnt + L);
    end
  endtask

  task automatic write_word(input logic [A-1:0] a, input logic [W-1:0] d);
    op(1'b1, 1'b1, a, d);
  endtask

  task automatic read_word(input logic [A-1:0] a);
    op(1'b1, 1'b0, a, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- monitor ----------------
  // Checks busy, data_valid timing/order and data_out hold every cycle.
  always @(negedge clk) begin
    neg_cnt++;
    if (!rst_n) begin
      checks++;
      if (data_valid !== 1'b0 || busy !== 1'b0 || data_out !== '0) begin
        errors++;
        $display("FAIL reset_state: valid=%b busy=%b data_out=%h, required 0 0 0000",
                 data_valid, busy, data_out);
      end
    end else begin
      checks++;
      if (busy !== (exp_q.size() != 0)) begin
        errors++;
        $display("FAIL busy: got %b, required %b (cycle %0d)", busy, exp_q.size() != 0, neg_cnt);
      end
      if (data_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_valid: data_out=%h with no read outstanding (cycle %0d)",
                   data_out, neg_cnt);
        end else begin
          if (data_out !== exp_q[0] || due_q[0] != neg_cnt) begin
            errors++;
            $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                     data_out, neg_cnt, exp_q[0], due_q[0]);
          end
          last_out = exp_q[0];
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end else begin
        checks++;
        if (data_out !== last_out) begin
          errors++;
          $display("FAIL data_hold: got %h, required %h (cycle %0d)", data_out, last_out, neg_cnt);
        end
        if (due_q.size() != 0 && due_q[0] <= neg_cnt) begin
          errors++;
          $display("FAIL missing_valid: no strobe, required %h at cycle %0d", exp_q[0], due_q[0]);
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(10);

    // Basic latency
    write_word(16'h0010, 16'hBEEF);
    read_word(16'h0010);
    idle(L + 2);

    // Back-to-back reads
    write_word(16'h0020, 16'h1111);
    write_word(16'h0021, 16'h2222);
    write_word(16'h0022, 16'h3333);
    write_word(16'h0023, 16'h4444);
    for (int i = 0; i < 4; i++) read_word(16'h0020 + 16'(i));
    idle(L + 2);

    // Snapshot: read in flight unaffected by a following write
    write_word(16'h0030, 16'h00AA);
    read_word(16'h0030);
    write_word(16'h0030, 16'h0055);
    read_word(16'h0030);
    idle(L + 2);

    // Boundary addresses
    write_word(16'h0000, 16'h0F0F);
    write_word(16'hFFFF, 16'hF0F0);
    read_word(16'hFFFF);
    read_word(16'h0000);
    idle(L + 2);

    // Reset mid-flight: three reads, reset before the first completes
    read_word(16'h0020);
    read_word(16'h0021);
    read_word(16'h0022);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    exp_q.delete();
    due_q.delete();
    last_out = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    idle(10);
    read_word(16'h0010);
    idle(L + 2);

`ifdef MEM_BYTE_WE_EN
    write_word(16'h0040, 16'h1234);
    be = 2'b10;
    write_word(16'h0040, 16'hABCD);
    be = '1;
    read_word(16'h0040);
    idle(L + 2);
`endif

    // Randomized traffic over a small pre-written address pool
    for (int i = 0; i < 16; i++) write_word(16'h0100 + 16'(i), 16'($urandom));
    for (int i = 0; i < 800; i++) begin
      int kind;
      logic [A-1:0] a;
      kind = $urandom_range(0, 9);
      a = 16'h0100 + 16'($urandom_range(0, 15));
`ifdef MEM_BYTE_WE_EN
      be = 2'($urandom_range(0, 3));
`endif
      if (kind < 2) idle(1);
      else if (kind < 5) write_word(a, 16'($urandom));
      else read_word(a);
    end
`ifdef MEM_BYTE_WE_EN
    be = '1;
`endif
    idle(L + 4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d reads outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
